// File: rtl/fu_pkg.sv
// Shared widths, status bit positions and Gselect codes for the function-unit operand/writeback stage.
package fu_pkg;

  localparam int unsigned FU_DATA_W = 32;
  localparam int unsigned FU_REG_N  = 8;
  localparam int unsigned FU_REG_AW = $clog2(FU_REG_N);

  localparam int unsigned STAT_Z = 0;
  localparam int unsigned STAT_N = 1;
  localparam int unsigned STAT_C = 2;
  localparam int unsigned STAT_V = 3;

  localparam logic [3:0] GSEL_TRANSFER_A = 4'b0000;
  localparam logic [3:0] GSEL_INC_A      = 4'b0001;
  localparam logic [3:0] GSEL_ADD        = 4'b0010;
  localparam logic [3:0] GSEL_ADD_INC    = 4'b0011;
  localparam logic [3:0] GSEL_SUB_DEC    = 4'b0100;
  localparam logic [3:0] GSEL_SUB        = 4'b0101;
  localparam logic [3:0] GSEL_DEC_A      = 4'b0110;
  localparam logic [3:0] GSEL_AND        = 4'b1000;
  localparam logic [3:0] GSEL_OR         = 4'b1010;
  localparam logic [3:0] GSEL_XOR        = 4'b1100;
  localparam logic [3:0] GSEL_NOT_A      = 4'b1110;

  // Packs ALU flags into the {V,C,N,Z} status layout.
  function automatic logic [3:0] pack_status(input logic v, input logic c,
                                             input logic n, input logic z);
    logic [3:0] s;
    s         = 4'b0000;
    s[STAT_V] = v;
    s[STAT_C] = c;
    s[STAT_N] = n;
    s[STAT_Z] = z;
    return s;
  endfunction

endpackage

// File: rtl/fu_regfile.sv
// General register file: two combinational operand reads, one debug read,
// one synchronous write port, cleared synchronously while rst_n is low.
module fu_regfile
  import fu_pkg::*;
#(
  parameter int unsigned DATA_W = FU_DATA_W,
  parameter int unsigned REG_N  = FU_REG_N,
  localparam int unsigned REG_AW = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ra_addr_i,
  input  logic [REG_AW-1:0] rb_addr_i,
  input  logic [REG_AW-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  output logic [DATA_W-1:0] rb_data_o,
  output logic [DATA_W-1:0] dbg_data_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] wa_i,
  input  logic [DATA_W-1:0] wd_i
);

  logic [DATA_W-1:0] mem_q [REG_N];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_N; i++) begin
        mem_q[REG_AW'(i)] <= '0;
      end
    end else if (we_i) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Reads return the pre-edge contents; same-edge writes are not bypassed here.
  assign ra_data_o  = mem_q[ra_addr_i];
  assign rb_data_o  = mem_q[rb_addr_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/fu_operand_wb.sv
// Operand-fetch / writeback stage around the combinational ALU.
// Build option FU_FWD_EN: forward alu_g into operands on a RAW hazard instead of stalling one cycle.
module fu_operand_wb
  import fu_pkg::*;
#(
  parameter int unsigned DATA_W = FU_DATA_W,
  parameter int unsigned REG_N  = FU_REG_N,
  localparam int unsigned REG_AW = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [REG_AW-1:0] cmd_da,
  input  logic [REG_AW-1:0] cmd_aa,
  input  logic [REG_AW-1:0] cmd_ba,
  input  logic              cmd_mb,
  input  logic [DATA_W-1:0] cmd_const,
  input  logic [3:0]        cmd_gsel,
  input  logic              cmd_rw,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_gsel,
  input  logic [DATA_W-1:0] alu_g,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_c,
  input  logic              alu_v,
  output logic [3:0]        status,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_da,
  output logic [DATA_W-1:0] wb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic              ex_valid_q, ex_valid_d;
  logic              ex_rw_q,    ex_rw_d;
  logic [REG_AW-1:0] ex_da_q,    ex_da_d;
  logic [DATA_W-1:0] ex_a_q,     ex_a_d;
  logic [DATA_W-1:0] ex_b_q,     ex_b_d;
  logic [3:0]        ex_gsel_q,  ex_gsel_d;
  logic [3:0]        status_q,   status_d;
  logic              wb_valid_q, wb_valid_d;
  logic [REG_AW-1:0] wb_da_q,    wb_da_d;
  logic [DATA_W-1:0] wb_data_q,  wb_data_d;

  logic [DATA_W-1:0] rf_a, rf_b;
  logic [DATA_W-1:0] op_a, op_b;
  logic              haz_a, haz_b;
  logic              accept;

  fu_regfile #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .ra_addr_i  (cmd_aa),
    .rb_addr_i  (cmd_ba),
    .dbg_addr_i (dbg_addr),
    .ra_data_o  (rf_a),
    .rb_data_o  (rf_b),
    .dbg_data_o (dbg_data),
    .we_i       (ex_valid_q && ex_rw_q),
    .wa_i       (ex_da_q),
    .wd_i       (alu_g)
  );

  // RAW detection against the op currently in execute; resolve by forwarding or by a one-cycle stall.
  always_comb begin
    haz_a = ex_valid_q && ex_rw_q && (ex_da_q == cmd_aa);
    haz_b = ex_valid_q && ex_rw_q && !cmd_mb && (ex_da_q == cmd_ba);
`ifdef FU_FWD_EN
    op_a      = haz_a ? alu_g : rf_a;
    op_b      = cmd_mb ? cmd_const : (haz_b ? alu_g : rf_b);
    cmd_ready = rst_n;
`else
    op_a      = rf_a;
    op_b      = cmd_mb ? cmd_const : rf_b;
    cmd_ready = rst_n && !(haz_a || haz_b);
`endif
    accept = cmd_valid && cmd_ready;
  end

  always_comb begin
    ex_valid_d = accept;
    ex_rw_d    = ex_rw_q;
    ex_da_d    = ex_da_q;
    ex_a_d     = ex_a_q;
    ex_b_d     = ex_b_q;
    ex_gsel_d  = ex_gsel_q;
    status_d   = status_q;
    wb_valid_d = 1'b0;
    wb_da_d    = wb_da_q;
    wb_data_d  = wb_data_q;
    if (accept) begin
      ex_rw_d   = cmd_rw;
      ex_da_d   = cmd_da;
      ex_a_d    = op_a;
      ex_b_d    = op_b;
      ex_gsel_d = cmd_gsel;
    end
    // Writeback: flags on every valid op, register data only when rw is set.
    if (ex_valid_q) begin
      status_d   = pack_status(alu_v, alu_c, alu_n, alu_z);
      wb_valid_d = ex_rw_q;
      wb_da_d    = ex_da_q;
      wb_data_d  = alu_g;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_rw_q    <= 1'b0;
      ex_da_q    <= '0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_gsel_q  <= 4'b0000;
      status_q   <= 4'b0000;
      wb_valid_q <= 1'b0;
      wb_da_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_rw_q    <= ex_rw_d;
      ex_da_q    <= ex_da_d;
      ex_a_q     <= ex_a_d;
      ex_b_q     <= ex_b_d;
      ex_gsel_q  <= ex_gsel_d;
      status_q   <= status_d;
      wb_valid_q <= wb_valid_d;
      wb_da_q    <= wb_da_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign alu_a    = ex_a_q;
  assign alu_b    = ex_b_q;
  assign alu_gsel = ex_gsel_q;
  assign status   = status_q;
  assign wb_valid = wb_valid_q;
  assign wb_da    = wb_da_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_fu_operand_wb.sv
// Directed bench for fu_operand_wb with a behavioural ALU; honours FU_FWD_EN for stall expectations.
module tb_fu_operand_wb;
  import fu_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned RN = 8;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_da = '0, cmd_aa = '0, cmd_ba = '0;
  logic          cmd_mb = 1'b0;
  logic [DW-1:0] cmd_const = '0;
  logic [3:0]    cmd_gsel = 4'b0000;
  logic          cmd_rw = 1'b0;
  logic [DW-1:0] alu_a, alu_b, alu_g;
  logic [3:0]    alu_gsel;
  logic          alu_z, alu_n, alu_c, alu_v;
  logic [3:0]    status;
  logic          wb_valid;
  logic [AW-1:0] wb_da;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_data;

  always #5 clk = ~clk;

  fu_operand_wb #(.DATA_W(DW), .REG_N(RN)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_da(cmd_da), .cmd_aa(cmd_aa), .cmd_ba(cmd_ba), .cmd_mb(cmd_mb),
    .cmd_const(cmd_const), .cmd_gsel(cmd_gsel), .cmd_rw(cmd_rw),
    .alu_a(alu_a), .alu_b(alu_b), .alu_gsel(alu_gsel),
    .alu_g(alu_g), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v),
    .status(status), .wb_valid(wb_valid), .wb_da(wb_da), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Stand-in for the combinational ALU (only ADD is exercised).
  logic [DW:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    alu_g   = alu_a;
    if (alu_gsel == GSEL_ADD) begin
      alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
      alu_g   = alu_sum[DW-1:0];
    end
    alu_c = alu_sum[DW];
    alu_n = alu_g[DW-1];
    alu_z = (alu_g == '0);
    alu_v = (alu_gsel == GSEL_ADD) && (alu_a[DW-1] == alu_b[DW-1]) && (alu_g[DW-1] != alu_a[DW-1]);
  end

  typedef struct packed {
    logic [AW-1:0] da;
    logic [DW-1:0] data;
  } wb_exp_t;

  wb_exp_t       exp_q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] m_rf [RN];
  logic [3:0]    m_stat;
  logic          acc = 1'b0, acc_rw = 1'b0, pend = 1'b0, pend_rw = 1'b0;
  logic [3:0]    acc_stat = 4'b0000, pend_stat = 4'b0000;
  logic          prev_live = 1'b0, prev_rw = 1'b0;
  logic [AW-1:0] prev_da = '0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and score the writeback of the op accepted two edges back.
  task automatic tick();
    wb_exp_t e;
    @(negedge clk);
    if (pend) begin
      chk("wb_valid", DW'(wb_valid), DW'(pend_rw));
      chk("status", DW'(status), DW'(pend_stat));
      if (pend_rw) begin
        if (exp_q.size() == 0) begin
          chk("wb_queue_empty", DW'(1), DW'(0));
        end else begin
          e = exp_q.pop_front();
          chk("wb_da", DW'(wb_da), DW'(e.da));
          chk("wb_data", wb_data, e.data);
        end
      end
    end else begin
      chk("wb_idle", DW'(wb_valid), DW'(0));
    end
    pend      = acc;
    pend_rw   = acc_rw;
    pend_stat = acc_stat;
    acc       = 1'b0;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
    prev_live = 1'b0;
  endtask

  task automatic dbg_all();
    for (int i = 0; i < int'(RN); i++) begin
      dbg_addr = AW'(i);
      #1;
      chk("dbg_rf", dbg_data, m_rf[AW'(i)]);
    end
  endtask

  // Drive one ADD command, wait for acceptance, check stall count, and book the expected writeback.
  task automatic issue(input logic [AW-1:0] da, input logic [AW-1:0] aa, input logic [AW-1:0] ba,
                       input logic mb, input logic [DW-1:0] k, input logic rw, input logic commit);
    int            stalls, exp_stall;
    logic [DW-1:0] a, b, g;
    logic [DW:0]   s;
    logic          v;
    tick();
    cmd_da = da; cmd_aa = aa; cmd_ba = ba; cmd_mb = mb; cmd_const = k;
    cmd_gsel = GSEL_ADD; cmd_rw = rw; cmd_valid = 1'b1;
`ifdef FU_FWD_EN
    exp_stall = 0;
`else
    exp_stall = (prev_live && prev_rw && (prev_da == aa || (!mb && prev_da == ba))) ? 1 : 0;
`endif
    stalls = 0;
    #1;
    while (!cmd_ready && stalls < 4) begin
      stalls++;
      tick();
      #1;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", DW'(0), DW'(1));
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("stall_cycles", DW'(stalls), DW'(exp_stall));
    a = m_rf[aa];
    b = mb ? k : m_rf[ba];
    s = {1'b0, a} + {1'b0, b};
    g = s[DW-1:0];
    v = (a[DW-1] & b[DW-1] & ~g[DW-1]) | (~a[DW-1] & ~b[DW-1] & g[DW-1]);
    if (commit) begin
      m_stat   = {v, s[DW], g[DW-1], (g == '0)};
      acc      = 1'b1;
      acc_rw   = rw;
      acc_stat = m_stat;
      if (rw) begin
        m_rf[da] = g;
        exp_q.push_back('{da: da, data: g});
      end
    end
    prev_live = 1'b1;
    prev_rw   = rw;
    prev_da   = da;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(RN); i++) m_rf[i] = '0;
    m_stat = 4'b0000;

    // Reset held over two rising edges.
    @(posedge clk);
    tick();
    chk("ready_in_reset", DW'(cmd_ready), DW'(0));
    chk("status_reset", DW'(status), DW'(0));
    chk("alu_a_reset", alu_a, '0);
    chk("alu_gsel_reset", DW'(alu_gsel), DW'(0));
    dbg_all();
    tick();
    rst_n = 1'b1;

    issue(3'd1, 3'd0, 3'd0, 1'b1, 32'h5A5A5A5A, 1'b1, 1'b1);
    issue(3'd2, 3'd0, 3'd0, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b1);
    issue(3'd3, 3'd1, 3'd2, 1'b0, 32'h0, 1'b1, 1'b1);
    issue(3'd4, 3'd3, 3'd0, 1'b1, 32'h1, 1'b1, 1'b1);
    issue(3'd5, 3'd1, 3'd2, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(3);
    chk("status_after_rw0", DW'(status), DW'(4'b0010));
    dbg_all();

    // Reset lands during the execute cycle of R6 = R1 + 1: op must be dropped.
    issue(3'd6, 3'd1, 3'd0, 1'b1, 32'h1, 1'b1, 1'b0);
    tick();
    rst_n = 1'b0;
    tick();
    chk("ready_mid_reset", DW'(cmd_ready), DW'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < int'(RN); i++) m_rf[i] = '0;
    m_stat = 4'b0000;
    prev_live = 1'b0;
    idle(2);
    chk("status_post_reset", DW'(status), DW'(0));
    dbg_all();

    // Signed overflow and carry-out with both operands hazarding.
    issue(3'd1, 3'd0, 3'd0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
    issue(3'd2, 3'd1, 3'd0, 1'b1, 32'h1, 1'b1, 1'b1);
    issue(3'd7, 3'd2, 3'd2, 1'b0, 32'h0, 1'b1, 1'b1);
    idle(3);
    chk("status_final", DW'(status), DW'(4'b1101));
    chk("wb_queue_drained", DW'(exp_q.size()), DW'(0));
    dbg_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
